fib_sequencer: RTL

Start/done-handshaked controller that sequences the three-register ALU datapath of the Fibonacci unit. It seeds the registers, then repeats an add / write / compare loop until the datapath reports the newest term exceeds the external limit. It rotates register roles so no copy cycles are needed. It drives the same 9-bit control word the datapath already decodes and sits between the top-level command logic and that datapath.

---
 rtl/fib_ctrl_pkg.sv | 51 +++++
 rtl/fib_role_rot.sv | 58 +++++
 rtl/fib_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fib_ctrl_pkg.sv
// Shared encodings for the Fibonacci sequencer: FSM states, control-word layout,
// ALU operation codes and register/mux select codes.
package fib_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit0,
        StInit1,
        StSel,
        StAdd,
        StWrb,
        StCmp,
        StDone
    } state_e;

    localparam int unsigned SigW  = 9;
    localparam int unsigned AluHi = 8;
    localparam int unsigned AluLo = 7;
    localparam int unsigned MuxAHi = 6;
    localparam int unsigned MuxALo = 5;
    localparam int unsigned MuxBHi = 4;
    localparam int unsigned MuxBLo = 3;
    localparam int unsigned RegHi = 2;
    localparam int unsigned RegLo = 1;
    localparam int unsigned WBit  = 0;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluInc  = 2'b01;
    localparam logic [1:0] AluPass = 2'b10;
    localparam logic [1:0] AluCmp  = 2'b11;

    localparam logic [1:0] RegR1     = 2'b00;
    localparam logic [1:0] RegR2     = 2'b01;
    localparam logic [1:0] RegR3     = 2'b10;
    localparam logic [1:0] MuxAZero  = 2'b11;
    localparam logic [1:0] MuxBLimit = 2'b11;

    function automatic logic [SigW-1:0] ctrl_word(input logic [1:0] alu, input logic [1:0] mux_a,
                                                  input logic [1:0] mux_b, input logic [1:0] reg_sel,
                                                  input logic w);
        logic [SigW-1:0] word;
        word                = '0;
        word[AluHi:AluLo]   = alu;
        word[MuxAHi:MuxALo] = mux_a;
        word[MuxBHi:MuxBLo] = mux_b;
        word[RegHi:RegLo]   = reg_sel;
        word[WBit]          = w;
        return word;
    endfunction

endpackage

// File: rtl/fib_role_rot.sv
// Mod-3 role pointer: maps p to the old/new/dest register codes so the
// datapath never has to copy registers between iterations.
module fib_role_rot
    import fib_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    input  logic       hold,
    output logic [1:0] old_code,
    output logic [1:0] new_code,
    output logic [1:0] dest_code
);

    logic [1:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (clr) begin
            p_d = 2'd0;
        end else if (adv && !hold) begin
            p_d = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= 2'd0;
        end else begin
            p_q <= p_d;
        end
    end

    always_comb begin
        old_code  = RegR1;
        new_code  = RegR2;
        dest_code = RegR3;
        unique case (p_q)
            2'd1: begin
                old_code  = RegR2;
                new_code  = RegR3;
                dest_code = RegR1;
            end
            2'd2: begin
                old_code  = RegR3;
                new_code  = RegR1;
                dest_code = RegR2;
            end
            default: begin
                old_code  = RegR1;
                new_code  = RegR2;
                dest_code = RegR3;
            end
        endcase
    end

endmodule

// File: rtl/fib_sequencer.sv
// Start/done controller sequencing the three-register Fibonacci datapath.
// Optional iteration cap enabled by defining ITER_LIMIT_EN.
module fib_sequencer
    import fib_ctrl_pkg::*;
#(
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned MAX_ITER = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              mayor,
    output logic [SigW-1:0]   o_signal,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] o_iter,
    output logic [1:0]        o_res_sel
);

    localparam logic [ITER_W-1:0] IterMax = '1;

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
    logic [1:0]        res_q, res_d;
    logic              err_q, err_d;
    logic              rot_clr, rot_adv;
    logic [1:0]        old_code, new_code, dest_code;
    logic [SigW-1:0]   sig;

`ifdef ITER_LIMIT_EN
    localparam logic [ITER_W-1:0] IterCap = ITER_W'(MAX_ITER);
`else
    logic unused_max_iter;
    assign unused_max_iter = ^MAX_ITER;
`endif

    fib_role_rot u_role_rot (
        .clk       (clk),
        .rst       (rst),
        .clr       (rot_clr),
        .adv       (rot_adv),
        .hold      (hold),
        .old_code  (old_code),
        .new_code  (new_code),
        .dest_code (dest_code)
    );

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        res_d    = res_q;
        err_d    = err_q;
        rot_clr  = 1'b0;
        rot_adv  = 1'b0;
        iter_inc = (iter_q == IterMax) ? iter_q : iter_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit0;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    rot_clr = 1'b1;
                end
            end
            StInit0: if (!hold) state_d = StInit1;
            StInit1: if (!hold) state_d = StSel;
            StSel:   if (!hold) state_d = StAdd;
            StAdd:   if (!hold) state_d = StWrb;
            StWrb:   if (!hold) state_d = StCmp;
            StCmp: begin
                if (!hold) begin
                    if (mayor) begin
                        state_d = StDone;
                        res_d   = dest_code;
                    end else begin
                        state_d = StSel;
                        iter_d  = iter_inc;
                        rot_adv = 1'b1;
`ifdef ITER_LIMIT_EN
                        if (iter_inc == IterCap) begin
                            state_d = StDone;
                            err_d   = 1'b1;
                            res_d   = dest_code;
                        end
`endif
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            iter_q  <= '0;
            res_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Moore decode; reg field is don't-care (r1) in states that do not write.
    always_comb begin
        sig = '0;
        unique case (state_q)
            StInit0:      sig = ctrl_word(AluPass, MuxAZero, RegR1, RegR1, 1'b1);
            StInit1:      sig = ctrl_word(AluInc, MuxAZero, RegR1, RegR2, 1'b1);
            StSel, StAdd: sig = ctrl_word(AluAdd, old_code, new_code, RegR1, 1'b0);
            StWrb:        sig = ctrl_word(AluAdd, old_code, new_code, dest_code, 1'b1);
            StCmp:        sig = ctrl_word(AluCmp, dest_code, MuxBLimit, RegR1, 1'b0);
            default:      sig = '0;
        endcase
    end

    // Write enable is the only output allowed to see an input combinationally.
    always_comb begin
        o_signal       = sig;
        o_signal[WBit] = sig[WBit] & ~hold;
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign o_iter    = iter_q;
    assign o_res_sel = res_q;

endmodule
